// File: rtl/vdp_bus_if.sv
// CPU-side bus interface for the VDP: synchronizes the asynchronous Z80-style strobes,
// qualifies them against glitches and issues single-clock read/write ticks to VRAM.
module vdp_bus_if #(
    parameter int MIN_LOW = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] cpu_din,
    input  logic [7:0] vram_dout,
    input  logic [7:0] status_in,
    output logic       rd_tick,
    output logic       wr_tick,
    output logic       mode,
    output logic [7:0] din,
    output logic [7:0] cpu_dout,
    output logic       cpu_doe
);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        QUAL,
        RD_HOLD,
        WR_HOLD
    } state_t;

    localparam logic [2:0] MIN_CNT = 3'(MIN_LOW);
    localparam logic [2:0] SETTLE  = 3'd2;

    function automatic logic [2:0] sat_inc(input logic [2:0] value, input logic [2:0] limit);
        sat_inc = (value >= limit) ? limit : value + 3'd1;
    endfunction

    state_t      state;
    logic [2:0]  cnt;
    logic        dir_wr;
    logic [11:0] sync_p0;
    logic [11:0] sync_p1;

    logic       iorq_n_s;
    logic       rd_n_s;
    logic       wr_n_s;
    logic       a0_s;
    logic [7:0] cpu_din_s;
    logic       sel_rd;
    logic       sel_wr;
    logic       strobe;

    assign iorq_n_s  = sync_p1[11];
    assign rd_n_s    = sync_p1[10];
    assign wr_n_s    = sync_p1[9];
    assign a0_s      = sync_p1[8];
    assign cpu_din_s = sync_p1[7:0];

    assign sel_rd = !iorq_n_s && !rd_n_s;
    assign sel_wr = !iorq_n_s && !wr_n_s;
    assign strobe = dir_wr ? sel_wr : sel_rd;

    assign cpu_doe = !iorq_n && !rd_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0  <= '1;
            sync_p1  <= '1;
            state    <= WAIT_IDLE;
            cnt      <= 3'd0;
            dir_wr   <= 1'b0;
            rd_tick  <= 1'b0;
            wr_tick  <= 1'b0;
            mode     <= 1'b0;
            din      <= 8'h00;
            cpu_dout <= 8'h00;
        end else begin
            // stage p0/p1: two-flop synchronizer on every asynchronous CPU pin
            sync_p0 <= {iorq_n, rd_n, wr_n, a0, cpu_din};
            sync_p1 <= sync_p0;

            rd_tick  <= 1'b0;
            wr_tick  <= 1'b0;
            cpu_dout <= mode ? status_in : vram_dout;

            // stage p2: strobe qualification and tick generation on synchronized values
            case (state)
                WAIT_IDLE: begin
                    // The synchronizer restarts from all-ones, so require a few clean
                    // clocks before trusting that no access is still in flight.
                    if (sel_rd || sel_wr) begin
                        cnt <= 3'd0;
                    end else if (cnt == SETTLE) begin
                        cnt   <= 3'd0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                IDLE: begin
                    if (sel_rd ^ sel_wr) begin
                        cnt    <= 3'd1;
                        dir_wr <= sel_wr;
                        state  <= QUAL;
                    end
                end
                QUAL: begin
                    if (!strobe || (sel_rd && sel_wr)) begin
                        cnt   <= 3'd0;
                        state <= IDLE;
                    end else if (cnt == MIN_CNT) begin
                        mode <= a0_s;
                        if (dir_wr) begin
                            din     <= cpu_din_s;
                            wr_tick <= 1'b1;
                            state   <= WR_HOLD;
                        end else begin
                            state <= RD_HOLD;
                        end
                    end else begin
                        cnt <= sat_inc(cnt, MIN_CNT);
                    end
                end
                RD_HOLD: begin
                    // Tick on the trailing edge so VRAM only advances after the CPU sampled.
                    if (!sel_rd) begin
                        rd_tick <= 1'b1;
                        cnt     <= 3'd0;
                        state   <= IDLE;
                    end
                end
                WR_HOLD: begin
                    if (!sel_wr) begin
                        cnt   <= 3'd0;
                        state <= IDLE;
                    end
                end
                default: begin
                    cnt   <= 3'd0;
                    state <= WAIT_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vdp_bus_if.sv
// Scoreboard bench for vdp_bus_if: stimulus pushes expected ticks, a negedge monitor
// pops and compares them whenever rd_tick or wr_tick appears.
module tb_vdp_bus_if;

    localparam int MIN_LOW = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       iorq_n, rd_n, wr_n, a0;
    logic [7:0] cpu_din, vram_dout, status_in;
    logic       rd_tick, wr_tick, mode, cpu_doe;
    logic [7:0] din, cpu_dout;

    vdp_bus_if #(.MIN_LOW(MIN_LOW)) dut (
        .clk(clk), .reset(reset), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .a0(a0), .cpu_din(cpu_din), .vram_dout(vram_dout), .status_in(status_in),
        .rd_tick(rd_tick), .wr_tick(wr_tick), .mode(mode), .din(din),
        .cpu_dout(cpu_dout), .cpu_doe(cpu_doe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit         is_wr;
        bit         mode;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every tick must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rd_tick || wr_tick) begin
            exp_t e;
            chk("tick_exclusive", {31'd0, rd_tick && wr_tick}, 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_tick", {30'd0, rd_tick, wr_tick}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("tick_kind", {31'd0, wr_tick}, {31'd0, e.is_wr});
                chk("tick_mode", {31'd0, mode}, {31'd0, e.mode});
                chk("tick_cycle", cyc, e.cyc);
                if (e.is_wr) chk("wr_din", {24'd0, din}, {24'd0, e.data});
                else         chk("rd_cpu_dout", {24'd0, cpu_dout}, {24'd0, e.data});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // kind: 0 read, 1 write, 2 read+write together, 3 strobe without iorq_n.
    // Called #1 after a clock edge; holds the strobe low for len clocks.
    task automatic access(input int kind, input bit a0v, input logic [7:0] data,
                          input int len, input int gap, input bit chk_dout);
        int fall;
        a0        = a0v;
        cpu_din   = (kind == 1) ? data : 8'($urandom);
        vram_dout = (kind == 0 && !a0v) ? data : 8'($urandom);
        status_in = (kind == 0 && a0v) ? data : 8'($urandom);
        iorq_n    = (kind == 3);
        rd_n      = !(kind == 0 || kind == 2 || (kind == 3 && a0v));
        wr_n      = !(kind == 1 || kind == 2 || (kind == 3 && !a0v));
        fall      = cyc;
        // A strobe is accepted once it has stayed low longer than MIN_LOW clocks.
        if (kind == 1 && len > MIN_LOW)
            q.push_back('{is_wr: 1'b1, mode: a0v, data: data, cyc: fall + 2 + MIN_LOW + 1});
        repeat (len) @(posedge clk);
        #1;
        if (chk_dout) begin
            chk("dout_while_low", {24'd0, cpu_dout}, {24'd0, data});
            chk("mode_while_low", {31'd0, mode}, {31'd0, a0v});
        end
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        if (kind == 0 && len > MIN_LOW)
            q.push_back('{is_wr: 1'b0, mode: a0v, data: data, cyc: cyc + 3});
        idle(gap);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a0 = 1'b0;
        cpu_din = 8'h00; vram_dout = 8'h00; status_in = 8'h00;
        idle(3);
        chk("rst_rd_tick", {31'd0, rd_tick}, 32'd0);
        chk("rst_wr_tick", {31'd0, wr_tick}, 32'd0);
        chk("rst_mode", {31'd0, mode}, 32'd0);
        chk("rst_din", {24'd0, din}, 32'd0);
        chk("rst_cpu_dout", {24'd0, cpu_dout}, 32'd0);
        iorq_n = 1'b0; rd_n = 1'b0;
        #1 chk("doe_in_reset", {31'd0, cpu_doe}, 32'd1);
        iorq_n = 1'b1;
        #1 chk("doe_off", {31'd0, cpu_doe}, 32'd0);
        rd_n = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(6);

        access(1, 1'b0, 8'hA5, 6, 5, 1'b0);
        access(0, 1'b1, 8'h80, 6, 5, 1'b1);
        access(1, 1'b0, 8'h5A, 1, 5, 1'b0);
        access(1, 1'b1, 8'h33, 3, 5, 1'b0);
        access(2, 1'b0, 8'hEE, 5, 5, 1'b0);
        access(1, 1'b0, 8'h01, 4, 2, 1'b0);
        access(1, 1'b0, 8'h02, 4, 2, 1'b0);
        access(1, 1'b0, 8'h03, 4, 5, 1'b0);

        // Reset in the middle of a held read: the trailing edge must be ignored.
        a0 = 1'b1; status_in = 8'h3C; iorq_n = 1'b0; rd_n = 1'b0;
        idle(6);
        reset = 1'b1;
        idle(2);
        chk("midrst_mode", {31'd0, mode}, 32'd0);
        chk("midrst_cpu_dout", {24'd0, cpu_dout}, 32'd0);
        reset = 1'b0;
        idle(4);
        iorq_n = 1'b1; rd_n = 1'b1;
        idle(8);
        access(0, 1'b0, 8'hC3, 5, 5, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int k;
            k = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 1) : $urandom_range(2, 3);
            access(k, 1'($urandom), 8'($urandom), $urandom_range(1, 6),
                   $urandom_range(4, 7), 1'b0);
        end

        idle(12);
        chk("queue_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
